simon_param_core: RTL and testbench
===================================

# simon_param_core

Parametrised iterative SIMON block cipher core. It supports every SIMON variant: 32/64, 48/72, 48/96, 64/96, 64/128, 96/96, 96/144, 128/128, 128/192 and 128/256. The core expands a loaded key once into a round-key store, then encrypts or decrypts any number of blocks against that store at one round per clock. It is the drop-in successor to the fixed-width SIMON tops and uses the same load/done handshake towards the host interface.

## Interface
- N, 48: word size in bits (16, 24, 32, 48, 64)
- M, 2: key words (2, 3, 4)
- T, 52: round count; must match the SIMON table for (N,M)
- Co, 6: round counter width, $clog2(T)
- ZSEL, 2: z sequence index 0..4 per the SIMON table for (N,M)
- clk  input  1  clock; all logic on rising edge
- nR  input  1  synchronous active-low reset
- newKey  input  1  request to load key
- newData  input  1  request to process plain
- enc_dec  input  1  1 = encrypt, 0 = decrypt; sampled with newData
- readData  input  1  host has consumed cipher
- key  input  M×N (packed [M-1:0][N-1:0])  key[0] = k0 (least significant word)
- plain  input  2N  input block; [2N-1:N] = x, [N-1:0] = y
- ldKey  output  1  one-cycle pulse: key accepted
- ldData  output  1  one-cycle pulse: block accepted
- doneKey  output  1  level: round keys valid
- doneData  output  1  level: cipher valid, awaiting readData
- cipher  output  2N  result block, same x/y layout

## Operation
- FSM states: IDLE (no key), KEXP, READY, RUN, DONE.
- IDLE: newKey → KEXP. newData is ignored.
- READY:
  - newKey → KEXP. It has priority over a simultaneous newData, and no ldData is issued.
  - Otherwise newData → RUN, latching plain and enc_dec.
- KEXP:
  - Words k0..k(M-1) are written to the store on accept.
  - Then one word per cycle for i = M..T-1: tmp = ror(k[i-1],3); if M==4, tmp ^= k[i-3]; tmp ^= ror(tmp,1); k[i] = ~k[i-M] ^ tmp ^ z[(i-M) mod 62] ^ 3.
  - After T-M cycles → READY.
- RUN, one round per cycle with f(a) = (rol(a,1) & rol(a,8)) ^ rol(a,2):
  - Encrypt uses i = 0..T-1: (x,y) ← (y ^ f(x) ^ k[i], x).
  - Decrypt uses i = T-1..0: (x,y) ← (y, x ^ f(y) ^ k[i]).
  - After the last round, cipher ← {x,y} → DONE.
- DONE: readData → READY. newKey and newData are ignored, including newData in the same cycle as readData.
- newKey in KEXP, RUN or DONE is ignored: no ldKey is issued and the state is unchanged.
- readData outside DONE is ignored.
- doneKey is 1 in READY, RUN and DONE. It drops the cycle after a new key is accepted.
- cipher changes only on entry to DONE and holds until the next completion.
- All arithmetic is mod 2^N. Rotations are within N bits. The round counter wraps only by FSM control and never free-runs.

## Timing
- Reset (nR low at an edge): state IDLE; ldKey, ldData, doneKey, doneData = 0; cipher = 0; counter = 0.
- The round-key store is not reset.
- Reset mid-KEXP or mid-RUN aborts; the key must be reloaded.
- Key accept edge E0: ldKey is high for the cycle after E0. doneKey rises T-M cycles after ldKey rises.
- Data accept edge E0: ldData is high for the cycle after E0. Round i completes at edge E(i+1). doneData rises T cycles after ldData rises.
- Throughput: one block per T+2 cycles with readData asserted immediately.
- ldKey and ldData are never high together.

## Configuration
- SIMON_DEC_EN defined: decryption path and reverse key addressing are present; enc_dec is honoured.
- SIMON_DEC_EN undefined: encrypt-only. enc_dec is ignored and treated as 1, and the decrypt datapath is not built.
- Key storage is retained in both builds, because the keys are reused across blocks.

## Structure
- Package simon_pkg holds:
  - the state enum;
  - Z0..Z4 as 62-bit constants from the SIMON specification, stored so that bit j (LSB = j 0) is z_j;
  - rol/ror functions parametrised by N.
- Sub-module simon_key_store holds the T×N round-key register array, the expansion datapath and the write/read addressing. It receives its round index from the top FSM.

## Test plan
- SIMON_32/64 (N=16, M=4, T=32, ZSEL=0): key {1918,1110,0908,0100}, plain 65656877, encrypt → cipher c69be9bb, doneData 32 cycles after ldData.
- SIMON_96/96 (defaults): key {0d0c0b0a0908,050403020100}, plain 2072616c6c69702065687420 → cipher 602807a462b469063d8ff082. With SIMON_DEC_EN, decrypting that cipher returns the plain.
- newKey and newData asserted together in READY → ldKey only, KEXP entered, doneKey low for 50 cycles.
- newData in IDLE after reset → no ldData, state stays IDLE. readData in READY → no effect.
- nR low during round 20 of RUN → all outputs 0 next cycle. After reloading the key, the first 96/96 vector still passes.
- Two back-to-back blocks with one key load → both correct. cipher holds the first result until the second completes, and doneData stays high until readData.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared state type, z-sequence constants and width-generic rotate helpers for the SIMON core.
package simon_pkg;

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_READY, S_RUN, S_DONE} state_e;

  function automatic logic [61:0] rev62(input logic [61:0] v);
    logic [61:0] r;
    for (int j = 0; j < 62; j++) r[j] = v[61-j];
    return r;
  endfunction

  // Literals are written z_0 first, then flipped so that bit j holds z_j.
  localparam logic [61:0] Z0 = rev62(62'b11111010001001010110000111001101111101000100101011000011100110);
  localparam logic [61:0] Z1 = rev62(62'b10001110111110010011000010110101000111011111001001100001011010);
  localparam logic [61:0] Z2 = rev62(62'b10101111011100000011010010011000101000010001111110010110110011);
  localparam logic [61:0] Z3 = rev62(62'b11011011101011000110010111100000010010001010011100110100001111);
  localparam logic [61:0] Z4 = rev62(62'b11010001111001101011011000100000010111000011001010010011101111);

  function automatic logic [61:0] z_sel(input int unsigned sel);
    case (sel)
      0:       return Z0;
      1:       return Z1;
      2:       return Z2;
      3:       return Z3;
      default: return Z4;
    endcase
  endfunction

  function automatic logic [63:0] wmask(input int unsigned n);
    return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  // Operands are zero-extended N-bit words; n is the word size N.
  function automatic logic [63:0] rol(input logic [63:0] a, input int unsigned s, input int unsigned n);
    return ((a << s) | (a >> (n - s))) & wmask(n);
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] a, input int unsigned s, input int unsigned n);
    return ((a >> s) | (a << (n - s))) & wmask(n);
  endfunction

endpackage

// File: rtl/simon_key_store.sv
// Round-key register file with the one-word-per-cycle SIMON key expansion.
module simon_key_store
  import simon_pkg::*;
#(
  parameter int N    = 48,
  parameter int M    = 2,
  parameter int T    = 52,
  parameter int Co   = 6,
  parameter int ZSEL = 2
) (
  input  logic                clk,
  input  logic                load_i,
  input  logic [M-1:0][N-1:0] key_i,
  input  logic                exp_en_i,
  input  logic [Co-1:0]       idx_i,
  output logic [N-1:0]        rk_o
);

  localparam logic [61:0] ZSEQ = z_sel(ZSEL);

  logic [N-1:0] ks_q [T];
  logic [N-1:0] km1, kmm, km3, tmp_a, tmp_b, k_d;
  logic [6:0]   zj;
  logic         zbit;

  assign rk_o = ks_q[idx_i];
  assign km1  = ks_q[idx_i - Co'(1)];
  assign kmm  = ks_q[idx_i - Co'(M)];

  generate
    if (M == 4) begin : g_m4
      assign km3 = ks_q[idx_i - Co'(3)];
    end else begin : g_m23
      assign km3 = '0;
    end
  endgenerate

  always_comb begin
    tmp_a = N'(ror(64'(km1), 3, N)) ^ km3;
    tmp_b = tmp_a ^ N'(ror(64'(tmp_a), 1, N));
    // z index is (i-M) mod 62; i-M never reaches 124, so one subtraction suffices.
    zj = 7'(idx_i) - 7'(M);
    if (zj >= 7'd62) zj = zj - 7'd62;
    zbit = |(ZSEQ & (62'd1 << zj));
    k_d  = ~kmm ^ tmp_b ^ N'(3) ^ N'(zbit);
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      for (int w = 0; w < M; w++) ks_q[w] <= key_i[w];
    end else if (exp_en_i) begin
      ks_q[idx_i] <= k_d;
    end
  end

endmodule

// File: rtl/simon_param_core.sv
// Iterative SIMON core for any (N,M) variant: key expanded once, then one round per clock.
// Define SIMON_DEC_EN to build the decrypt datapath; otherwise the core is encrypt-only.
module simon_param_core
  import simon_pkg::*;
#(
  parameter int N    = 48,
  parameter int M    = 2,
  parameter int T    = 52,
  parameter int Co   = 6,
  parameter int ZSEL = 2
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                newKey,
  input  logic                newData,
  input  logic                enc_dec,
  input  logic                readData,
  input  logic [M-1:0][N-1:0] key,
  input  logic [2*N-1:0]      plain,
  output logic                ldKey,
  output logic                ldData,
  output logic                doneKey,
  output logic                doneData,
  output logic [2*N-1:0]      cipher
);

  state_e         state_q;
  logic [Co-1:0]  cnt_q;
  logic [N-1:0]   x_q, y_q, x_d, y_d, rk;
  logic [2*N-1:0] cipher_q;
  logic           ldKey_q, ldData_q, doneKey_q, doneData_q;
  logic           key_acc, last_round;

  function automatic logic [N-1:0] f_rnd(input logic [N-1:0] a);
    return (N'(rol(64'(a), 1, N)) & N'(rol(64'(a), 8, N))) ^ N'(rol(64'(a), 2, N));
  endfunction

  assign key_acc = nR && newKey && (state_q == S_IDLE || state_q == S_READY);

  simon_key_store #(.N(N), .M(M), .T(T), .Co(Co), .ZSEL(ZSEL)) u_key_store (
    .clk      (clk),
    .load_i   (key_acc),
    .key_i    (key),
    .exp_en_i (nR && state_q == S_KEXP),
    .idx_i    (cnt_q),
    .rk_o     (rk)
  );

`ifdef SIMON_DEC_EN
  logic dec_q;

  always_comb begin
    if (dec_q) begin
      x_d        = y_q;
      y_d        = x_q ^ f_rnd(y_q) ^ rk;
      last_round = (cnt_q == '0);
    end else begin
      x_d        = y_q ^ f_rnd(x_q) ^ rk;
      y_d        = x_q;
      last_round = (cnt_q == Co'(T-1));
    end
  end
`else
  logic unused_enc_dec;
  assign unused_enc_dec = enc_dec;
  assign x_d        = y_q ^ f_rnd(x_q) ^ rk;
  assign y_d        = x_q;
  assign last_round = (cnt_q == Co'(T-1));
`endif

  always_ff @(posedge clk) begin
    ldKey_q  <= 1'b0;
    ldData_q <= 1'b0;
    if (!nR) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cipher_q   <= '0;
      doneKey_q  <= 1'b0;
      doneData_q <= 1'b0;
`ifdef SIMON_DEC_EN
      dec_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (newKey) begin
          state_q <= S_KEXP;
          ldKey_q <= 1'b1;
          cnt_q   <= Co'(M);
        end
        S_KEXP: if (cnt_q == Co'(T-1)) begin
          state_q   <= S_READY;
          doneKey_q <= 1'b1;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + Co'(1);
        end
        S_READY: if (newKey) begin
          state_q   <= S_KEXP;
          ldKey_q   <= 1'b1;
          doneKey_q <= 1'b0;
          cnt_q     <= Co'(M);
        end else if (newData) begin
          state_q  <= S_RUN;
          ldData_q <= 1'b1;
          x_q      <= plain[2*N-1:N];
          y_q      <= plain[N-1:0];
`ifdef SIMON_DEC_EN
          dec_q    <= ~enc_dec;
          cnt_q    <= enc_dec ? '0 : Co'(T-1);
`else
          cnt_q    <= '0;
`endif
        end
        S_RUN: begin
          x_q <= x_d;
          y_q <= y_d;
          if (last_round) begin
            state_q    <= S_DONE;
            cipher_q   <= {x_d, y_d};
            doneData_q <= 1'b1;
            cnt_q      <= '0;
          end else begin
`ifdef SIMON_DEC_EN
            cnt_q <= dec_q ? cnt_q - Co'(1) : cnt_q + Co'(1);
`else
            cnt_q <= cnt_q + Co'(1);
`endif
          end
        end
        S_DONE: if (readData) begin
          state_q    <= S_READY;
          doneData_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ldKey    = ldKey_q;
  assign ldData   = ldData_q;
  assign doneKey  = doneKey_q;
  assign doneData = doneData_q;
  assign cipher   = cipher_q;

endmodule

// File: tb/tb_simon_param_core.sv
// Bench for simon_param_core: a 96/96 instance checked every cycle against a protocol and cipher model, plus a 32/64 instance.
module tb_simon_param_core;

  localparam logic [95:0] K96 = 96'h0d0c0b0a0908_050403020100;
  localparam logic [95:0] P96 = 96'h2072616c6c69_702065687420;
  localparam logic [95:0] C96 = 96'h602807a462b4_69063d8ff082;
  localparam logic [95:0] P2  = 96'h0123456789ab_cdef01234567;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // 96/96 instance (default parameters)
  logic nR, newKey, newData, enc_dec, readData;
  logic [1:0][47:0] key;
  logic [95:0] plain, cipher;
  logic ldKey, ldData, doneKey, doneData;

  // 32/64 instance
  logic nR_s, newKey_s, newData_s, enc_dec_s, readData_s;
  logic [3:0][15:0] key_s;
  logic [31:0] plain_s, cipher_s;
  logic ldKey_s, ldData_s, doneKey_s, doneData_s;

  simon_param_core dut (
    .clk(clk), .nR(nR), .newKey(newKey), .newData(newData), .enc_dec(enc_dec),
    .readData(readData), .key(key), .plain(plain), .ldKey(ldKey), .ldData(ldData),
    .doneKey(doneKey), .doneData(doneData), .cipher(cipher)
  );

  simon_param_core #(.N(16), .M(4), .T(32), .Co(5), .ZSEL(0)) dut32 (
    .clk(clk), .nR(nR_s), .newKey(newKey_s), .newData(newData_s), .enc_dec(enc_dec_s),
    .readData(readData_s), .key(key_s), .plain(plain_s), .ldKey(ldKey_s), .ldData(ldData_s),
    .doneKey(doneKey_s), .doneData(doneData_s), .cipher(cipher_s)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference cipher ----------------
  function automatic bit zbit(input int sel, input int j);
    string s;
    case (sel)
      0:       s = "11111010001001010110000111001101111101000100101011000011100110";
      1:       s = "10001110111110010011000010110101000111011111001001100001011010";
      2:       s = "10101111011100000011010010011000101000010001111110010110110011";
      3:       s = "11011011101011000110010111100000010010001010011100110100001111";
      default: s = "11010001111001101011011000100000010111000011001010010011101111";
    endcase
    return s[j] == 8'h31;
  endfunction

  function automatic logic [63:0] msk(input int n);
    return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] rl(input logic [63:0] a, input int s, input int n);
    return ((a << s) | (a >> (n - s))) & msk(n);
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] a, input int s, input int n);
    return ((a >> s) | (a << (n - s))) & msk(n);
  endfunction

  function automatic logic [63:0] fm(input logic [63:0] a, input int n);
    return (rl(a, 1, n) & rl(a, 8, n)) ^ rl(a, 2, n);
  endfunction

  function automatic logic [127:0] simon_model(input int n, input int m, input int t, input int zs,
                                               input logic [255:0] kv, input logic [127:0] blk, input bit enc);
    logic [63:0] k [80];
    logic [63:0] x, y, tmp;
    for (int i = 0; i < m; i++) k[i] = 64'(kv >> (i * n)) & msk(n);
    for (int i = m; i < t; i++) begin
      tmp = rr(k[i-1], 3, n);
      if (m == 4) tmp = tmp ^ k[i-3];
      tmp = tmp ^ rr(tmp, 1, n);
      k[i] = (~k[i-m] & msk(n)) ^ tmp ^ 64'(zbit(zs, (i - m) % 62)) ^ 64'd3;
    end
    x = 64'(blk >> n) & msk(n);
    y = 64'(blk) & msk(n);
    if (enc) begin
      for (int i = 0; i < t; i++) begin
        tmp = x;
        x = y ^ fm(x, n) ^ k[i];
        y = tmp;
      end
    end else begin
      for (int i = t - 1; i >= 0; i--) begin
        tmp = y;
        y = x ^ fm(y, n) ^ k[i];
        x = tmp;
      end
    end
    return (128'(x) << n) | 128'(y);
  endfunction

  // ---------------- cycle model of the 96/96 instance ----------------
  bit m_ldk = 0, m_ldd = 0, m_haskey = 0, m_done = 0;
  int kleft = 0, rleft = 0;
  logic [95:0] m_key = '0, m_res = '0, m_cipher = '0;

  initial forever begin
    bit e;
    @(posedge clk);
`ifdef SIMON_DEC_EN
    e = enc_dec;
`else
    e = 1'b1;
`endif
    m_ldk = 1'b0;
    m_ldd = 1'b0;
    if (!nR) begin
      m_haskey = 0; m_done = 0; kleft = 0; rleft = 0; m_cipher = '0;
    end else if (kleft > 0) begin
      kleft--;
      if (kleft == 0) m_haskey = 1;
    end else if (rleft > 0) begin
      rleft--;
      if (rleft == 0) begin m_cipher = m_res; m_done = 1; end
    end else if (m_done) begin
      if (readData) m_done = 0;
    end else if (newKey) begin
      m_ldk = 1; m_haskey = 0; kleft = 52 - 2; m_key = key;
    end else if (m_haskey && newData) begin
      m_ldd = 1; rleft = 52;
      m_res = 96'(simon_model(48, 2, 52, 2, 256'(m_key), 128'(plain), e));
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk1("ldKey", ldKey, m_ldk);
      chk1("ldData", ldData, m_ldd);
      chk1("doneKey", doneKey, m_haskey);
      chk1("doneData", doneData, m_done);
      chkv("cipher", 128'(cipher), 128'(m_cipher));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return doneKey;
      1:       return doneData;
      2:       return doneKey_s;
      default: return doneData_s;
    endcase
  endfunction

  task automatic wait_sig(input int sel, output int cyc);
    cyc = 0;
    while (sig_of(sel) !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_key();
    @(negedge clk); newKey = 1'b1;
    @(negedge clk); newKey = 1'b0;
  endtask

  task automatic pulse_data();
    @(negedge clk); newData = 1'b1;
    @(negedge clk); newData = 1'b0;
  endtask

  task automatic pulse_read();
    @(negedge clk); readData = 1'b1;
    @(negedge clk); readData = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [95:0] e2;
    nR = 0; newKey = 0; newData = 0; enc_dec = 1; readData = 0; key = K96; plain = '0;
    nR_s = 0; newKey_s = 0; newData_s = 0; enc_dec_s = 1; readData_s = 0; key_s = '0; plain_s = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk1("rst_ldKey", ldKey, 1'b0);
    chk1("rst_doneKey", doneKey, 1'b0);
    chk1("rst_doneData_32", doneData_s, 1'b0);
    chkv("rst_cipher_32", 128'(cipher_s), 128'd0);

    chkv("model_32_64", simon_model(16, 4, 32, 0, 256'(64'h1918111009080100), 128'(32'h65656877), 1'b1), 128'(32'hc69be9bb));
    chkv("model_96_enc", simon_model(48, 2, 52, 2, 256'(K96), 128'(P96), 1'b1), 128'(C96));
    chkv("model_96_dec", simon_model(48, 2, 52, 2, 256'(K96), 128'(C96), 1'b0), 128'(P96));
    nR = 1; nR_s = 1;

    // SIMON 32/64
    key_s = 64'h1918111009080100; plain_s = 32'h65656877;
    @(negedge clk); newKey_s = 1;
    @(negedge clk); newKey_s = 0;
    chk1("ldKey_32", ldKey_s, 1'b1);
    wait_sig(2, cyc);
    chkv("kexp_cycles_32", 128'(cyc), 128'd28);
    @(negedge clk); newData_s = 1;
    @(negedge clk); newData_s = 0;
    chk1("ldData_32", ldData_s, 1'b1);
    wait_sig(3, cyc);
    chkv("run_cycles_32", 128'(cyc), 128'd32);
    chkv("cipher_32", 128'(cipher_s), 128'(32'hc69be9bb));
    $display("32/64 block: cipher=%h after %0d cycles", cipher_s, cyc);

    // 96/96: newData in IDLE is ignored
    plain = P96;
    pulse_data();
    chk1("idle_ldData", ldData, 1'b0);
    $display("96/96 newData in IDLE: ldData=%b", ldData);

    pulse_key();
    chk1("ldKey_96", ldKey, 1'b1);
    wait_sig(0, cyc);
    chkv("kexp_cycles_96", 128'(cyc), 128'd50);
    $display("96/96 key load: doneKey after %0d cycles", cyc);

    pulse_read();
    chk1("ready_read_doneData", doneData, 1'b0);
    $display("96/96 readData in READY: doneKey=%b doneData=%b", doneKey, doneData);

    pulse_data();
    chk1("ldData_96", ldData, 1'b1);
    wait_sig(1, cyc);
    chkv("run_cycles_96", 128'(cyc), 128'd52);
    chkv("cipher_96", 128'(cipher), 128'(C96));
    $display("96/96 encrypt: cipher=%h after %0d cycles", cipher, cyc);
    pulse_read();

`ifdef SIMON_DEC_EN
    plain = C96; enc_dec = 0;
    pulse_data();
    wait_sig(1, cyc);
    chkv("decrypt_96", 128'(cipher), 128'(P96));
    $display("96/96 decrypt: result=%h", cipher);
    pulse_read();
    enc_dec = 1; plain = P96;
`else
    enc_dec = 0;
    pulse_data();
    wait_sig(1, cyc);
    chkv("encdec_ignored_96", 128'(cipher), 128'(C96));
    $display("96/96 enc_dec=0 in encrypt-only build: cipher=%h", cipher);
    pulse_read();
    enc_dec = 1;
`endif

    // newKey and newData together in READY
    @(negedge clk); newKey = 1; newData = 1;
    @(negedge clk); newKey = 0; newData = 0;
    chk1("collide_ldKey", ldKey, 1'b1);
    chk1("collide_ldData", ldData, 1'b0);
    wait_sig(0, cyc);
    chkv("collide_kexp_cycles", 128'(cyc), 128'd50);
    $display("96/96 newKey+newData in READY: doneKey low %0d cycles", cyc);

    // back-to-back blocks on one key
    pulse_data();
    wait_sig(1, cyc);
    chkv("b2b_first", 128'(cipher), 128'(C96));
    plain = P2;
    pulse_data();
    chk1("done_newData_ignored", ldData, 1'b0);
    repeat (3) @(negedge clk);
    chk1("doneData_held", doneData, 1'b1);
    @(negedge clk); readData = 1; newData = 1;
    @(negedge clk); readData = 0; newData = 0;
    chk1("read_with_newData_ldData", ldData, 1'b0);
    pulse_data();
    repeat (10) @(negedge clk);
    chkv("cipher_held", 128'(cipher), 128'(C96));
    wait_sig(1, cyc);
    e2 = 96'(simon_model(48, 2, 52, 2, 256'(K96), 128'(P2), 1'b1));
    chkv("b2b_second", 128'(cipher), 128'(e2));
    $display("96/96 second block: cipher=%h", cipher);
    pulse_read();

    // reset during round 20
    plain = P96;
    pulse_data();
    repeat (20) @(negedge clk);
    nR = 0;
    @(negedge clk);
    nR = 1;
    chk1("abort_ldData", ldData, 1'b0);
    chk1("abort_doneKey", doneKey, 1'b0);
    chk1("abort_doneData", doneData, 1'b0);
    chkv("abort_cipher", 128'(cipher), 128'd0);
    $display("96/96 reset mid-run: doneKey=%b cipher=%h", doneKey, cipher);
    pulse_data();
    chk1("abort_idle_ldData", ldData, 1'b0);
    pulse_key();
    wait_sig(0, cyc);
    pulse_data();
    wait_sig(1, cyc);
    chkv("reload_cipher_96", 128'(cipher), 128'(C96));
    $display("96/96 after reload: cipher=%h", cipher);
    pulse_read();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
